// File: rtl/arbpuf_pkg.sv
// arbpuf_pkg: shared constants, state type and LFSR helper for the arbiter
// PUF sequencing controller.
//   LFSR_TAPS  - feedback taps of the challenge-expansion LFSR (bits 31,21,1,0)
//   ZERO_SEED  - replacement seed used when the requester supplies all zeros
//   arb_state_t - controller state encoding
package arbpuf_pkg;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] ZERO_SEED = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_FIRE,
        ST_SAMPLE,
        ST_NEXT
    } arb_state_t;

    // Shift left, feedback is the XOR of the tapped bits.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        return {cur[30:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/arbpuf_sync.sv
// arbpuf_sync: two-flop synchroniser bringing the asynchronous PUF arbiter
// output into the clk_i domain.
//   clk_i  - system clock
//   rst_i  - synchronous active-high reset, clears both stages
//   d_i    - asynchronous input
//   q_o    - synchronised output
module arbpuf_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/arbpuf_ctrl.sv
// arbpuf_ctrl: sequencing controller for a 32-stage arbiter PUF.
// Expands a seed challenge with an LFSR into RESP_BITS sub-challenges, races
// each one VOTES times, majority-votes the results into response_o and counts
// the bits whose votes were not unanimous.
//   clk_i, rst_i      - clock, synchronous active-high reset
//   start_i           - request, accepted only when idle
//   challenge_i       - seed challenge captured on acceptance
//   busy_o            - high from the accepting edge until done
//   done_o            - one-cycle pulse when response_o/unstable_o are final
//   response_o        - voted response, first bit in the MSB
//   unstable_o        - number of non-unanimous bits
//   puf_challenge_o   - challenge to the PUF switch chain (current LFSR value)
//   puf_launch_o      - race launch to both PUF path inputs
//   puf_resp_i        - arbiter output, asynchronous to clk_i
module arbpuf_ctrl
    import arbpuf_pkg::*;
#(
    parameter int RESP_BITS     = 32,
    parameter int VOTES         = 7,
    parameter int SETTLE_CYCLES = 4,
    parameter int RACE_CYCLES   = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [31:0]                      challenge_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [RESP_BITS-1:0]             response_o,
    output logic [$clog2(RESP_BITS+1)-1:0]   unstable_o,
    output logic [31:0]                      puf_challenge_o,
    output logic                             puf_launch_o,
    input  logic                             puf_resp_i
);

    localparam int TMAX = (SETTLE_CYCLES > RACE_CYCLES) ? SETTLE_CYCLES : RACE_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam int VW   = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int BW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int OW   = $clog2(VOTES + 1);
    localparam int UW   = $clog2(RESP_BITS + 1);

    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] RACE_LAST   = TW'(RACE_CYCLES - 1);
    localparam logic [VW-1:0] VOTE_LAST   = VW'(VOTES - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);
    localparam logic [OW-1:0] ONES_HALF   = OW'(VOTES / 2);
    localparam logic [OW-1:0] ONES_ALL    = OW'(VOTES);

    arb_state_t     state;
    logic [31:0]    lfsr;
    logic [TW-1:0]  timer;
    logic [VW-1:0]  vote_cnt;
    logic [BW-1:0]  bit_cnt;
    logic [OW-1:0]  ones;
    logic           resp_sync;
    logic           voted;

    (* keep_hierarchy = "yes" *)
    arbpuf_sync u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (puf_resp_i),
        .q_o   (resp_sync)
    );

    assign puf_challenge_o = lfsr;
    assign voted           = (ones > ONES_HALF);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            lfsr         <= '0;
            timer        <= '0;
            vote_cnt     <= '0;
            bit_cnt      <= '0;
            ones         <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            response_o   <= '0;
            unstable_o   <= '0;
            puf_launch_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // Blocking acceptance during the done cycle makes the cycle
                    // after done_o the earliest point a new request is taken.
                    if (start_i && !done_o) begin
                        lfsr         <= (challenge_i == '0) ? ZERO_SEED : challenge_i;
                        response_o   <= '0;
                        unstable_o   <= '0;
                        timer        <= '0;
                        vote_cnt     <= '0;
                        bit_cnt      <= '0;
                        ones         <= '0;
                        busy_o       <= 1'b1;
                        puf_launch_o <= 1'b0;
                        state        <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (timer == SETTLE_LAST) begin
                        timer        <= '0;
                        puf_launch_o <= 1'b1;
                        state        <= ST_FIRE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_FIRE: begin
                    if (timer == RACE_LAST) begin
                        timer <= '0;
                        state <= ST_SAMPLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    // Launch is still high in this cycle; it drops on leaving.
                    ones         <= ones + OW'(resp_sync);
                    puf_launch_o <= 1'b0;
                    if (vote_cnt < VOTE_LAST) begin
                        vote_cnt <= vote_cnt + 1'b1;
                        state    <= ST_ARM;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    response_o <= (response_o << 1) | RESP_BITS'(voted);
                    if ((ones != '0) && (ones != ONES_ALL)) begin
                        unstable_o <= unstable_o + UW'(1);
                    end
                    ones     <= '0;
                    vote_cnt <= '0;
                    lfsr     <= lfsr_step(lfsr);
                    if (bit_cnt == BIT_LAST) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= ST_ARM;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbpuf_ctrl.sv
// tb_arbpuf_ctrl: self-checking bench for arbpuf_ctrl with a behavioural PUF
// stub, a launch/challenge protocol monitor and a majority-vote reference model.
module tb_arbpuf_ctrl;

    localparam int RESP_BITS     = 32;
    localparam int VOTES         = 7;
    localparam int SETTLE_CYCLES = 4;
    localparam int RACE_CYCLES   = 8;
    localparam int UW            = $clog2(RESP_BITS + 1);
    localparam int NRACE         = RESP_BITS * VOTES;
    localparam int L = RESP_BITS * (VOTES * (SETTLE_CYCLES + RACE_CYCLES + 1) + 1);

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 start_i = 1'b0;
    logic [31:0]          challenge_i = '0;
    logic                 busy_o;
    logic                 done_o;
    logic [RESP_BITS-1:0] response_o;
    logic [UW-1:0]        unstable_o;
    logic [31:0]          puf_challenge_o;
    logic                 puf_launch_o;
    logic                 puf_resp_i = 1'b0;

    int check_cnt = 0;
    int pass_cnt  = 0;

    arbpuf_ctrl #(
        .RESP_BITS     (RESP_BITS),
        .VOTES         (VOTES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .RACE_CYCLES   (RACE_CYCLES)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .challenge_i     (challenge_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .response_o      (response_o),
        .unstable_o      (unstable_o),
        .puf_challenge_o (puf_challenge_o),
        .puf_launch_o    (puf_launch_o),
        .puf_resp_i      (puf_resp_i)
    );

    always #5 clk_i = ~clk_i;

    // PUF stub + protocol monitor. Mode 0: constant 1, 1: toggles per race
    // starting at 1, 2: random per race. Values are chosen at each launch rise.
    int          stub_mode = 0;
    logic        clr_mon = 1'b0;
    int          n_races;
    logic        race_val [NRACE];
    logic [31:0] chal_log [NRACE];
    int          low_err, high_err, chal_err, stab_err;
    int          low_run, high_run, stable_run;
    logic        prev_launch = 1'b0;
    logic [31:0] prev_chal = '0;
    logic        toggle;

    always @(negedge clk_i) begin
        if (puf_challenge_o != prev_chal) stable_run = 1;
        else stable_run = stable_run + 1;
        prev_chal = puf_challenge_o;
        if (clr_mon) begin
            n_races = 0; low_err = 0; high_err = 0; chal_err = 0; stab_err = 0;
            low_run = 100; high_run = 0; toggle = 1'b1;
        end else if (puf_launch_o && !prev_launch) begin
            if (low_run < SETTLE_CYCLES) low_err = low_err + 1;
            if (stable_run < SETTLE_CYCLES + 1) stab_err = stab_err + 1;
            if (n_races < NRACE) begin
                chal_log[n_races] = puf_challenge_o;
                case (stub_mode)
                    0: race_val[n_races] = 1'b1;
                    1: begin race_val[n_races] = toggle; toggle = ~toggle; end
                    default: race_val[n_races] = 1'($urandom_range(0, 1));
                endcase
                puf_resp_i = race_val[n_races];
            end
            n_races  = n_races + 1;
            high_run = 1;
            low_run  = 0;
        end else if (puf_launch_o) begin
            high_run = high_run + 1;
            if (puf_challenge_o != chal_log[(n_races > 0) ? n_races - 1 : 0]) chal_err = chal_err + 1;
        end else begin
            if (prev_launch && high_run != RACE_CYCLES + 1) high_err = high_err + 1;
            low_run = low_run + 1;
        end
        prev_launch = puf_launch_o;
    end

    // Reference: challenge for sub-challenge k is the seed advanced k LFSR steps.
    function automatic logic [31:0] model_chal(input logic [31:0] seed, input int k);
        logic [31:0] x;
        logic        fb;
        x = (seed == 32'd0) ? 32'hFFFF_FFFF : seed;
        for (int i = 0; i < k; i++) begin
            fb = x[31] ^ x[21] ^ x[1] ^ x[0];
            x  = {x[30:0], fb};
        end
        return x;
    endfunction

    // Reference: majority over each group of VOTES recorded race outcomes.
    function automatic logic [RESP_BITS-1:0] model_resp();
        logic [RESP_BITS-1:0] r;
        int ones;
        r = '0;
        for (int b = 0; b < RESP_BITS; b++) begin
            ones = 0;
            for (int v = 0; v < VOTES; v++) ones += int'(race_val[b * VOTES + v]);
            r = {r[RESP_BITS-2:0], (ones > VOTES / 2)};
        end
        return r;
    endfunction

    function automatic int model_unstable();
        int n, ones;
        n = 0;
        for (int b = 0; b < RESP_BITS; b++) begin
            ones = 0;
            for (int v = 0; v < VOTES; v++) ones += int'(race_val[b * VOTES + v]);
            if (ones != 0 && ones != VOTES) n++;
        end
        return n;
    endfunction

    function automatic int chal_seq_errors(input logic [31:0] seed);
        int e;
        e = 0;
        for (int r = 0; r < NRACE; r++)
            if (chal_log[r] !== model_chal(seed, r / VOTES)) e++;
        return e;
    endfunction

    task automatic start_req(input logic [31:0] ch, input int mode);
        @(posedge clk_i); #1;
        stub_mode = mode;
        clr_mon = 1'b1;
        @(posedge clk_i); #1;
        clr_mon = 1'b0;
        challenge_i = ch;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit timed_out);
        cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < L + 200; i++) begin
            @(posedge clk_i); #1;
            cycles++;
            if (done_o) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic test_reset;
        // power-on reset values
        repeat (3) @(posedge clk_i);
        #1;
        check_cnt++; if ({busy_o, done_o, puf_launch_o} !== 3'b000) $display("FAIL por_ctrl: got %b required 000", {busy_o, done_o, puf_launch_o}); else pass_cnt++;
        check_cnt++; if (response_o !== '0) $display("FAIL por_resp: got %h required 0", response_o); else pass_cnt++;
        check_cnt++; if (puf_challenge_o !== '0) $display("FAIL por_chal: got %h required 0", puf_challenge_o); else pass_cnt++;
        rst_i = 1'b0;
        // reset in mid-run after some results exist
        start_req(32'hCAFE_0001, 2);
        repeat (300) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy_o); else pass_cnt++;
        check_cnt++; if (puf_launch_o !== 1'b0) $display("FAIL rst_launch: got %b required 0", puf_launch_o); else pass_cnt++;
        check_cnt++; if (response_o !== '0) $display("FAIL rst_resp: got %h required 0", response_o); else pass_cnt++;
        check_cnt++; if (unstable_o !== '0) $display("FAIL rst_unstable: got %0d required 0", unstable_o); else pass_cnt++;
        check_cnt++; if (puf_challenge_o !== '0) $display("FAIL rst_chal: got %h required 0", puf_challenge_o); else pass_cnt++;
        repeat (2) begin
            @(posedge clk_i); #1;
            check_cnt++; if (done_o !== 1'b0) $display("FAIL rst_done: got %b required 0", done_o); else pass_cnt++;
        end
        rst_i = 1'b0;
        repeat (20) begin
            @(posedge clk_i); #1;
            check_cnt++; if ({busy_o, done_o} !== 2'b00) $display("FAIL post_rst_idle: got %b required 00", {busy_o, done_o}); else pass_cnt++;
        end
    endtask

    task automatic test_constant;
        int cycles;
        bit to;
        start_req(32'h1234_5678, 0);
        check_cnt++; if (busy_o !== 1'b1) $display("FAIL const_busy: got %b required 1", busy_o); else pass_cnt++;
        wait_done(cycles, to);
        check_cnt++; if (to || cycles != L) $display("FAIL const_latency: got %0d cycles (timeout %0d) required %0d", cycles, to, L); else pass_cnt++;
        check_cnt++; if (busy_o !== 1'b0) $display("FAIL const_busy_end: got %b required 0", busy_o); else pass_cnt++;
        check_cnt++; if (response_o !== 32'hFFFF_FFFF) $display("FAIL const_resp: got %h required ffffffff", response_o); else pass_cnt++;
        check_cnt++; if (unstable_o !== '0) $display("FAIL const_unstable: got %0d required 0", unstable_o); else pass_cnt++;
        check_cnt++; if (chal_seq_errors(32'h1234_5678) != 0) $display("FAIL const_chal_seq: got %0d wrong challenges required 0", chal_seq_errors(32'h1234_5678)); else pass_cnt++;
        // protocol monitor results for this full run
        check_cnt++; if (n_races != NRACE) $display("FAIL proto_rises: got %0d required %0d", n_races, NRACE); else pass_cnt++;
        check_cnt++; if (low_err != 0) $display("FAIL proto_low: got %0d short low phases required 0", low_err); else pass_cnt++;
        check_cnt++; if (high_err != 0) $display("FAIL proto_high: got %0d bad high phases required 0", high_err); else pass_cnt++;
        check_cnt++; if (chal_err != 0) $display("FAIL proto_chal_hold: got %0d changes required 0", chal_err); else pass_cnt++;
        check_cnt++; if (stab_err != 0) $display("FAIL proto_chal_settle: got %0d violations required 0", stab_err); else pass_cnt++;
        @(posedge clk_i); #1;
        check_cnt++; if (done_o !== 1'b0) $display("FAIL done_pulse: got %b required 0", done_o); else pass_cnt++;
    endtask

    task automatic test_toggle;
        int cycles;
        bit to;
        start_req(32'h0BAD_F00D, 1);
        wait_done(cycles, to);
        check_cnt++; if (to || cycles != L) $display("FAIL tog_latency: got %0d required %0d", cycles, L); else pass_cnt++;
        check_cnt++; if (response_o !== 32'hAAAA_AAAA) $display("FAIL tog_resp: got %h required aaaaaaaa", response_o); else pass_cnt++;
        check_cnt++; if (unstable_o !== UW'(32)) $display("FAIL tog_unstable: got %0d required 32", unstable_o); else pass_cnt++;
    endtask

    task automatic test_random;
        int cycles;
        bit to;
        logic [31:0] seed;
        logic [RESP_BITS-1:0] exp_r;
        int exp_u;
        for (int n = 0; n < 3; n++) begin
            seed = $urandom;
            start_req(seed, 2);
            wait_done(cycles, to);
            exp_r = model_resp();
            exp_u = model_unstable();
            check_cnt++; if (to || cycles != L) $display("FAIL rnd_latency: got %0d required %0d", cycles, L); else pass_cnt++;
            check_cnt++; if (response_o !== exp_r) $display("FAIL rnd_resp: got %h required %h", response_o, exp_r); else pass_cnt++;
            check_cnt++; if (unstable_o !== UW'(exp_u)) $display("FAIL rnd_unstable: got %0d required %0d", unstable_o, exp_u); else pass_cnt++;
            check_cnt++; if (chal_seq_errors(seed) != 0) $display("FAIL rnd_chal_seq: got %0d wrong required 0", chal_seq_errors(seed)); else pass_cnt++;
            repeat (25) @(posedge clk_i);
            #1;
            check_cnt++; if (response_o !== exp_r) $display("FAIL rnd_hold: got %h required %h", response_o, exp_r); else pass_cnt++;
        end
    endtask

    task automatic test_seeds;
        int cycles;
        bit to;
        start_req(32'h0000_0000, 2);
        check_cnt++; if (puf_challenge_o !== 32'hFFFF_FFFF) $display("FAIL seed0_first: got %h required ffffffff", puf_challenge_o); else pass_cnt++;
        wait_done(cycles, to);
        check_cnt++; if (chal_log[0] !== 32'hFFFF_FFFF) $display("FAIL seed0_race0: got %h required ffffffff", chal_log[0]); else pass_cnt++;
        start_req(32'h0000_0001, 2);
        wait_done(cycles, to);
        check_cnt++; if (chal_log[0] !== 32'h0000_0001) $display("FAIL seed1_first: got %h required 00000001", chal_log[0]); else pass_cnt++;
        check_cnt++; if (chal_log[VOTES] !== 32'h0000_0003) $display("FAIL seed1_second: got %h required 00000003", chal_log[VOTES]); else pass_cnt++;
        check_cnt++; if (chal_seq_errors(32'h1) != 0) $display("FAIL seed1_seq: got %0d wrong required 0", chal_seq_errors(32'h1)); else pass_cnt++;
    endtask

    task automatic test_busy_start_and_abort;
        int cycles;
        bit to;
        logic [31:0] c0;
        start_req(32'h5555_0F0F, 0);
        repeat (99) @(posedge clk_i);
        #1;
        c0 = puf_challenge_o;
        challenge_i = 32'h0000_0000;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check_cnt++; if (busy_o !== 1'b1) $display("FAIL busy_start_busy: got %b required 1", busy_o); else pass_cnt++;
        check_cnt++; if (puf_challenge_o !== c0) $display("FAIL busy_start_chal: got %h required %h", puf_challenge_o, c0); else pass_cnt++;
        repeat (399) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check_cnt++; if ({busy_o, puf_launch_o} !== 2'b00) $display("FAIL abort_idle: got %b required 00", {busy_o, puf_launch_o}); else pass_cnt++;
        start_req(32'h7777_1111, 0);
        wait_done(cycles, to);
        check_cnt++; if (to || cycles != L) $display("FAIL fresh_latency: got %0d required %0d", cycles, L); else pass_cnt++;
        check_cnt++; if (response_o !== 32'hFFFF_FFFF) $display("FAIL fresh_resp: got %h required ffffffff", response_o); else pass_cnt++;
        check_cnt++; if (chal_seq_errors(32'h7777_1111) != 0) $display("FAIL fresh_seq: got %0d wrong required 0", chal_seq_errors(32'h7777_1111)); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_constant;
        test_toggle;
        test_random;
        test_seeds;
        test_busy_start_and_abort;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
